// File: rtl/scratch_pad_ctrl.sv
// Valid/ready front-end for a 1RW synchronous SRAM with a 2-entry read-response FIFO.
// Optional accepted-request counters are enabled by defining SCRATCH_PAD_CTRL_PERF_EN.
module scratch_pad_ctrl #(
    parameter int  DWidth = 8,
    parameter int  Depth  = 1024,
    localparam int Index  = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [Index-1:0]  req_addr_i,
    input  logic [DWidth-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWidth-1:0] rsp_data_o,
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic              sram_oeb_o,
    output logic [Index-1:0]  sram_addr_o,
    output logic [DWidth-1:0] sram_data_o,
    input  logic [DWidth-1:0] sram_data_i,
    output logic              busy_o
`ifdef SCRATCH_PAD_CTRL_PERF_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
`endif
);

    logic              inflight;
    logic [1:0]        count;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [DWidth-1:0] fifo_mem [2];
    logic [Index-1:0]  addr_q;
    logic [DWidth-1:0] data_q;
    logic              accept;
    logic              pop;
    logic              push;

    // Reset masks acceptance so no SRAM access is started while rst_ni is low.
    assign accept = req_valid_i && req_ready_o && rst_ni;
    assign pop    = rsp_valid_o && rsp_ready_i;
    assign push   = inflight;

    // One credit per outstanding read (in flight or buffered); a same-cycle pop frees one.
    assign req_ready_o = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign rsp_valid_o = (count != 2'd0);
    assign rsp_data_o  = fifo_mem[rd_ptr];
    assign busy_o      = inflight | (count != 2'd0);

    assign sram_csb_o  = ~accept;
    assign sram_web_o  = ~(accept && req_we_i);
    assign sram_oeb_o  = ~inflight;
    assign sram_addr_o = accept ? req_addr_i  : addr_q;
    assign sram_data_o = accept ? req_wdata_i : data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight    <= 1'b0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            inflight <= accept && !req_we_i;
            if (accept) begin
                addr_q <= req_addr_i;
                data_q <= req_wdata_i;
            end
            // Read data is valid on the pins exactly one cycle after issue.
            if (push) begin
                fifo_mem[wr_ptr] <= sram_data_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef SCRATCH_PAD_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (accept) begin
            if (req_we_i) begin
                if (wr_cnt_o != 32'hFFFF_FFFF) wr_cnt_o <= wr_cnt_o + 32'd1;
            end else begin
                if (rd_cnt_o != 32'hFFFF_FFFF) rd_cnt_o <= rd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scratch_pad_ctrl.sv
// Randomized bench for scratch_pad_ctrl: SRAM behavioural model plus a shadow-memory /
// outstanding-read queue reference that predicts every output each cycle.
module tb_scratch_pad_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int IW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [IW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          csb, web, oeb;
    logic [IW-1:0] saddr;
    logic [DW-1:0] sdata_o;
    logic [DW-1:0] sdata_i = '0;
    logic          busy;
`ifdef SCRATCH_PAD_CTRL_PERF_EN
    logic [31:0]   rd_cnt, wr_cnt;
    int            rd_n = 0, wr_n = 0;
`endif

    scratch_pad_ctrl #(.DWidth(DW), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .sram_csb_o(csb), .sram_web_o(web), .sram_oeb_o(oeb),
        .sram_addr_o(saddr), .sram_data_o(sdata_o), .sram_data_i(sdata_i),
        .busy_o(busy)
`ifdef SCRATCH_PAD_CTRL_PERF_EN
        , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous 1RW SRAM; reset never touches its contents.
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) sram[saddr] <= sdata_o;
            else      sdata_i     <= sram[saddr];
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            checks = 0, failures = 0, cyc = 0;
    bit            hold_pending = 0;
    logic [DW-1:0] hold_val = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_csb"}, csb, 1);
        chk({tag, "_web"}, web, 1);
        chk({tag, "_oeb"}, oeb, 1);
        chk({tag, "_addr"}, saddr, 0);
        chk({tag, "_data"}, sdata_o, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef SCRATCH_PAD_CTRL_PERF_EN
        chk({tag, "_rd_cnt"}, rd_cnt, 0);
        chk({tag, "_wr_cnt"}, wr_cnt, 0);
`endif
    endtask

    // One clock cycle: drive inputs, predict and compare at negedge, then advance the model.
    task automatic step(input bit v, input bit we, input logic [IW-1:0] a,
                        input logic [DW-1:0] d, input bit rr);
        bit ev, pop, er, acc;
        int n;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
        @(negedge clk);
        ev  = (q.size() > 0) && (q[0].c + 2 <= cyc);
        pop = ev && rr;
        n   = q.size() - (pop ? 1 : 0);
        er  = (n < 2);
        acc = v && er;
        chk("rsp_valid", rsp_valid, ev);
        chk("req_ready", req_ready, er);
        chk("busy", busy, (q.size() > 0) && (q[0].c < cyc));
        chk("oeb", oeb, !((q.size() > 0) && (q[$].c == cyc - 1)));
        chk("csb", csb, !acc);
        chk("web", web, !(acc && we));
        if (acc) begin
            chk("sram_addr", saddr, a);
            chk("sram_data", sdata_o, d);
        end
        if (hold_pending) chk("rsp_hold", rsp_data, hold_val);
        if (pop) begin
            chk("rsp_data", rsp_data, q[0].d);
            q.pop_front();
        end
        hold_pending = ev && !rr;
        hold_val     = rsp_data;
`ifdef SCRATCH_PAD_CTRL_PERF_EN
        chk("rd_cnt", rd_cnt, rd_n);
        chk("wr_cnt", wr_cnt, wr_n);
        if (acc) begin
            if (we) wr_n++;
            else    rd_n++;
        end
`endif
        if (acc) begin
            if (we) ref_mem[a] = d;
            else    q.push_back('{d: ref_mem[a], c: cyc});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 1);
    endtask

    initial begin
        logic [IW-1:0] ra;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        #2;
        chk_reset_vals("por");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // write then read the same address next cycle
        step(1, 1, 10'd0, 8'hA5, 1);
        step(1, 0, 10'd0, 8'h00, 1);
        idle(3);

        // top address, then ordering across two reads
        step(1, 1, 10'd1023, 8'h3C, 1);
        step(1, 0, 10'd1023, 8'h00, 1);
        step(1, 0, 10'd0, 8'h00, 1);
        idle(3);

        // fill some words, then 16 back-to-back reads
        for (int i = 0; i < 16; i++) step(1, 1, 10'(i + 16), 8'(i * 7 + 3), 1);
        for (int i = 0; i < 16; i++) step(1, 0, 10'(i + 16), 8'h00, 1);
        idle(3);

        // backpressure: only two reads accepted while rsp_ready is low
        for (int i = 0; i < 6; i++) step(1, 0, 10'(i + 16), 8'h00, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 10'(i + 20), 8'h00, 1);
        idle(3);

        // reset with one entry buffered and one read in flight
        step(1, 1, 10'd7, 8'h5A, 1);
        step(1, 0, 10'd7, 8'h00, 0);
        step(1, 0, 10'd7, 8'h00, 0);
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd7; req_wdata = 8'hFF;
        rsp_ready = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        @(negedge clk);
        chk_reset_vals("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        hold_pending = 0;
`ifdef SCRATCH_PAD_CTRL_PERF_EN
        rd_n = 0; wr_n = 0;
`endif
        cyc++;
        idle(3);
        step(1, 0, 10'd7, 8'h00, 1);
        idle(3);

        // randomized traffic, addresses biased toward edges and a small hot range
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 10'd0;
                1:       ra = 10'd1023;
                default: ra = 10'($urandom_range(0, 7));
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra,
                 8'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(4);
        chk("drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scratch_pad_ctrl.md
Name: scratch_pad_ctrl

Overview:
Request/response front-end for the scratch-pad SRAM wrapper (1RW, synchronous, active-low CSB/WEB/OEB). It accepts single-beat read/write requests on a valid/ready port and drives the SRAM pins. It captures read data one cycle after issue and returns it through a 2-entry response FIFO with valid/ready backpressure. It sits between the MLP datapath/loader and the SRAM wrapper.

Parameters:
DWidth, 8, data word width in bits
Depth, 1024, number of SRAM words
Index, $clog2(Depth), address width (localparam)

Ports:
clk_i  in  1  clock; also drives the SRAM CE pin
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  Index  word address
req_wdata_i  in  DWidth  write data
rsp_valid_o  out  1  read response valid
rsp_ready_i  in  1  response consumer ready
rsp_data_o  out  DWidth  read data, in request order
sram_csb_o  out  1  SRAM chip select, active low
sram_web_o  out  1  SRAM write enable, active low
sram_oeb_o  out  1  SRAM output enable, active low
sram_addr_o  out  Index  SRAM address
sram_data_o  out  DWidth  SRAM write data
sram_data_i  in  DWidth  SRAM read data
busy_o  out  1  read in flight or FIFO non-empty

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, sram_csb_o=1, sram_web_o=1, sram_oeb_o=1, sram_addr_o=0, sram_data_o=0, busy_o=0. FIFO empty, inflight=0.
- SRAM pins are combinational from the request port.
  - On accept: csb=0, addr=req_addr_i, web=~req_we_i, data=req_wdata_i.
  - With no accept: csb=1, web=1; addr and data hold their last values.
- Issue timing: a request accepted in cycle N is sampled by the SRAM at the clk_i edge ending cycle N.
  - Read: inflight flag set for cycle N+1. In N+1 oeb=0, sram_data_i is valid and is pushed into the FIFO at the end of N+1. Otherwise oeb=1.
- Read latency: the earliest rsp_valid_o is cycle N+2 (registered FIFO output). Writes produce no response.
- Credit rule: req_ready_o = (inflight + fifo_count - pop) < 2, where pop = rsp_valid_o && rsp_ready_i.
  - The rule is independent of req_we_i; writes also stall when credit is exhausted, which preserves ordering.
  - The FIFO therefore never overflows.
- Throughput: with rsp_ready_i held at 1, one read or write is accepted per cycle indefinitely.
- FIFO: 2 entries, first-word-fall-through from registers.
  - Push and pop in the same cycle are allowed at any occupancy.
  - rsp_data_o holds stable while rsp_valid_o=1 and rsp_ready_i=0.
- Write followed by a read of the same address in the next cycle returns the new data; the SRAM is synchronous, so no forwarding is needed.
- Addresses cover 0..Depth-1 with no wrap logic. Address Depth-1 is legal.
- busy_o = inflight | (fifo_count != 0).
- Reset mid-operation: any in-flight read is discarded and the FIFO is cleared. SRAM contents are not touched, and no write is issued during reset.

Optional Feature:
Macro SCRATCH_PAD_CTRL_PERF_EN.
- When defined, adds ports rd_cnt_o (out, 32) and wr_cnt_o (out, 32).
  - They count accepted reads and accepted writes.
  - Both are saturating at 32'hFFFF_FFFF, reset to 0, and cleared only by rst_ni.
- When undefined, these ports and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Write 8'hA5 to addr 0, then read addr 0 on the next cycle, rsp_ready_i=1 -> rsp_valid_o asserts 2 cycles after read accept with rsp_data_o=8'hA5; csb/web/oeb toggle as specified.
- Write addr 1023=8'h3C; read 1023 and addr 0 -> responses 8'h3C then the addr-0 value, in order.
- 16 back-to-back reads with rsp_ready_i=1 -> req_ready_o stays 1, 16 responses on consecutive cycles starting at cycle N+2.
- rsp_ready_i=0, issue reads continuously -> exactly 2 accepted, then req_ready_o=0 and rsp_data_o stable. Raise rsp_ready_i -> both drain in order, and acceptance resumes the same cycle as the first pop.
- Assert rst_ni low for 1 cycle while a read is in flight and the FIFO holds 1 entry -> all outputs at reset values immediately, no response emitted after release, SRAM data preserved on a re-read.
- With SCRATCH_PAD_CTRL_PERF_EN defined: 5 writes and 7 reads -> wr_cnt_o=5, rd_cnt_o=7. Force the counter to 32'hFFFF_FFFF, issue 1 more read -> rd_cnt_o remains 32'hFFFF_FFFF.
